// File: rtl/bank_scatter_writer_if.sv
// -----------------------------------------------------------------------------
// bank_scatter_writer_if
//
// Bundles the word stream (valid/ready/data) and the two registered bank
// write ports (F bank, S bank) that bank_scatter_writer drives.
//
//   in_valid / in_data / in_ready : word stream into the writer
//   f_we / f_addr / f_wdata       : F bank write port
//   s_we / s_addr / s_wdata       : S bank write port
//
// Modports:
//   slave  : the writer's view (consumes the stream, drives the bank ports)
//   master : the surrounding system's view (produces the stream, observes
//            the bank ports)
// -----------------------------------------------------------------------------
interface bank_scatter_writer_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    logic              f_we;
    logic [4:0]        f_addr;
    logic [DATA_W-1:0] f_wdata;

    logic              s_we;
    logic [4:0]        s_addr;
    logic [DATA_W-1:0] s_wdata;

    modport slave (
        input  in_valid, in_data,
        output in_ready,
        output f_we, f_addr, f_wdata,
        output s_we, s_addr, s_wdata
    );

    modport master (
        output in_valid, in_data,
        input  in_ready,
        input  f_we, f_addr, f_wdata,
        input  s_we, s_addr, s_wdata
    );
endinterface

// File: rtl/bank_scatter_writer.sv
// -----------------------------------------------------------------------------
// bank_scatter_writer
//
// Burst writer for the F/S register bank pair. A start command (sampled only
// while idle) selects the target bank, the first entry and the burst length.
// Each stream word accepted during the burst becomes a one-cycle registered
// write strobe on the selected bank port; the address advances mod 32.
//
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   start      : burst command strobe, sampled in IDLE only
//   bank_sel   : 0 = F bank, 1 = S bank (latched on accepted start)
//   base_addr  : first entry written (latched on accepted start)
//   length     : words in burst, legal 1..DEPTH (latched on accepted start)
//   bus        : stream in + F/S bank write ports (slave modport)
//   busy       : high while a burst is in progress
//   done       : one-cycle pulse coincident with the final write strobe
//   err        : one-cycle pulse after a start with an illegal length
// -----------------------------------------------------------------------------
module bank_scatter_writer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 bank_sel,
    input  logic [4:0]           base_addr,
    input  logic [5:0]           length,
    bank_scatter_writer_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam logic [5:0] MAX_LEN = 6'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              bank_q, bank_d;           // 0 = F, 1 = S
    logic [4:0]        addr_ptr_q, addr_ptr_d;
    logic [5:0]        remaining_q, remaining_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              f_we_q, f_we_d;
    logic [4:0]        f_addr_q, f_addr_d;
    logic [DATA_W-1:0] f_wdata_q, f_wdata_d;
    logic              s_we_q, s_we_d;
    logic [4:0]        s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;

    logic              length_ok;
    logic              accept;

    assign length_ok = (length != 6'd0) && (length <= MAX_LEN);
    // busy_q mirrors state_q == BURST, so in_ready comes straight from a flop.
    assign accept    = busy_q & bus.in_valid;

    always_comb begin
        // NOTE: every _d is given its hold/idle value first, so no branch can
        // leave one unassigned and no latch is inferred.
        state_d     = state_q;
        bank_d      = bank_q;
        addr_ptr_d  = addr_ptr_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        f_we_d      = 1'b0;
        f_addr_d    = f_addr_q;
        f_wdata_d   = f_wdata_q;
        s_we_d      = 1'b0;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length_ok) begin
                        bank_d      = bank_sel;
                        addr_ptr_d  = base_addr;
                        remaining_d = length;
                        busy_d      = 1'b1;
                        state_d     = BURST;
                    end else begin
                        // Illegal length: flag it and latch nothing.
                        err_d = 1'b1;
                    end
                end
            end

            BURST: begin
                // start is deliberately not looked at here: the latched
                // command stays fixed until the burst completes.
                if (accept) begin
                    if (bank_q) begin
                        s_we_d    = 1'b1;
                        s_addr_d  = addr_ptr_q;
                        s_wdata_d = bus.in_data;
                    end else begin
                        f_we_d    = 1'b1;
                        f_addr_d  = addr_ptr_q;
                        f_wdata_d = bus.in_data;
                    end
                    // 5-bit add wraps 31 -> 0 on its own.
                    addr_ptr_d  = addr_ptr_q + 5'd1;
                    remaining_d = remaining_q - 6'd1;
                    if (remaining_q == 6'd1) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the write-data registers are reset as well, so the banks
            // see an all-zero port image (not X) right out of reset.
            state_q     <= IDLE;
            bank_q      <= 1'b0;
            addr_ptr_q  <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            f_we_q      <= 1'b0;
            f_addr_q    <= '0;
            f_wdata_q   <= '0;
            s_we_q      <= 1'b0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others, independent of statement order.
            state_q     <= state_d;
            bank_q      <= bank_d;
            addr_ptr_q  <= addr_ptr_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            f_we_q      <= f_we_d;
            f_addr_q    <= f_addr_d;
            f_wdata_q   <= f_wdata_d;
            s_we_q      <= s_we_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
        end
    end

    assign bus.in_ready = busy_q;
    assign bus.f_we     = f_we_q;
    assign bus.f_addr   = f_addr_q;
    assign bus.f_wdata  = f_wdata_q;
    assign bus.s_we     = s_we_q;
    assign bus.s_addr   = s_addr_q;
    assign bus.s_wdata  = s_wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
endmodule

// File: tb/tb_bank_scatter_writer.sv
// -----------------------------------------------------------------------------
// tb_bank_scatter_writer
//
// Cycle table for the continuous bursts and illegal-length starts, followed by
// hand-written sequences for stalls, a start issued mid-burst, and reset
// asserted mid-burst. Inputs change 1 time unit after the rising edge;
// outputs are compared at that same point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_bank_scatter_writer;
    localparam int DATA_W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        bank_sel;
    logic [4:0]  base_addr;
    logic [5:0]  length;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    bank_scatter_writer_if #(.DATA_W(DATA_W)) bus ();

    bank_scatter_writer #(.DATA_W(DATA_W), .DEPTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bank_sel  (bank_sel),
        .base_addr (base_addr),
        .length    (length),
        .bus       (bus.slave),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        bank_sel;
        logic [4:0]  base;
        logic [5:0]  len;
        logic        valid;
        logic [31:0] data;
        logic        e_busy;
        logic        e_fwe;
        logic [4:0]  e_faddr;
        logic [31:0] e_fdata;
        logic        e_swe;
        logic [4:0]  e_saddr;
        logic [31:0] e_sdata;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic b, input logic [4:0] ba,
                         input logic [5:0] l, input logic v, input logic [31:0] d);
        start        = s;
        bank_sel     = b;
        base_addr    = ba;
        length       = l;
        bus.in_valid = v;
        bus.in_data  = d;
    endtask

    task automatic expect_out(input string tag, input logic e_busy,
                              input logic e_fwe, input logic [4:0] e_faddr, input logic [31:0] e_fdata,
                              input logic e_swe, input logic [4:0] e_saddr, input logic [31:0] e_sdata,
                              input logic e_done, input logic e_err);
        check($sformatf("%s busy", tag),     32'(busy),         32'(e_busy));
        check($sformatf("%s in_ready", tag), 32'(bus.in_ready), 32'(e_busy));
        check($sformatf("%s f_we", tag),     32'(bus.f_we),     32'(e_fwe));
        check($sformatf("%s f_addr", tag),   32'(bus.f_addr),   32'(e_faddr));
        check($sformatf("%s f_wdata", tag),  bus.f_wdata,       e_fdata);
        check($sformatf("%s s_we", tag),     32'(bus.s_we),     32'(e_swe));
        check($sformatf("%s s_addr", tag),   32'(bus.s_addr),   32'(e_saddr));
        check($sformatf("%s s_wdata", tag),  bus.s_wdata,       e_sdata);
        check($sformatf("%s done", tag),     32'(done),         32'(e_done));
        check($sformatf("%s err", tag),      32'(err),          32'(e_err));
    endtask

    function automatic vec_t mk(input logic s, input logic b, input logic [4:0] ba, input logic [5:0] l,
                                input logic v, input logic [31:0] d,
                                input logic eb, input logic efw, input logic [4:0] efa, input logic [31:0] efd,
                                input logic esw, input logic [4:0] esa, input logic [31:0] esd,
                                input logic edn, input logic eer);
        vec_t r;
        r.start = s;  r.bank_sel = b;  r.base = ba;  r.len = l;  r.valid = v;  r.data = d;
        r.e_busy = eb;  r.e_fwe = efw;  r.e_faddr = efa;  r.e_fdata = efd;
        r.e_swe = esw;  r.e_saddr = esa;  r.e_sdata = esd;  r.e_done = edn;  r.e_err = eer;
        return r;
    endfunction

    initial begin
        int k;
        int strobes;
        logic [5:0] stall_pat;

        //                 st b  base len v  data          busy fwe fa fd        swe sa  sd        dn er
        // F burst base 0, length 4, A0..A3
        vecs[0]  = mk(1, 0, 5'd0,  6'd4,  0, 32'h0,        1, 0, 5'd0, 32'h0,  0, 5'd0,  32'h0,  0, 0);
        vecs[1]  = mk(0, 0, 5'd0,  6'd0,  1, 32'hA0,       1, 1, 5'd0, 32'hA0, 0, 5'd0,  32'h0,  0, 0);
        vecs[2]  = mk(0, 0, 5'd0,  6'd0,  1, 32'hA1,       1, 1, 5'd1, 32'hA1, 0, 5'd0,  32'h0,  0, 0);
        vecs[3]  = mk(0, 0, 5'd0,  6'd0,  1, 32'hA2,       1, 1, 5'd2, 32'hA2, 0, 5'd0,  32'h0,  0, 0);
        vecs[4]  = mk(0, 0, 5'd0,  6'd0,  1, 32'hA3,       0, 1, 5'd3, 32'hA3, 0, 5'd0,  32'h0,  1, 0);
        // S burst base 30 wrapping, start sampled in the done cycle
        vecs[5]  = mk(1, 1, 5'd30, 6'd4,  0, 32'h0,        1, 0, 5'd3, 32'hA3, 0, 5'd0,  32'h0,  0, 0);
        vecs[6]  = mk(0, 0, 5'd0,  6'd0,  1, 32'hB0,       1, 0, 5'd3, 32'hA3, 1, 5'd30, 32'hB0, 0, 0);
        vecs[7]  = mk(0, 0, 5'd0,  6'd0,  1, 32'hB1,       1, 0, 5'd3, 32'hA3, 1, 5'd31, 32'hB1, 0, 0);
        vecs[8]  = mk(0, 0, 5'd0,  6'd0,  1, 32'hB2,       1, 0, 5'd3, 32'hA3, 1, 5'd0,  32'hB2, 0, 0);
        vecs[9]  = mk(0, 0, 5'd0,  6'd0,  1, 32'hB3,       0, 0, 5'd3, 32'hA3, 1, 5'd1,  32'hB3, 1, 0);
        // illegal lengths 0 and 33, then a stray word while idle
        vecs[10] = mk(1, 1, 5'd9,  6'd0,  0, 32'h0,        0, 0, 5'd3, 32'hA3, 0, 5'd1,  32'hB3, 0, 1);
        vecs[11] = mk(0, 0, 5'd0,  6'd0,  0, 32'h0,        0, 0, 5'd3, 32'hA3, 0, 5'd1,  32'hB3, 0, 0);
        vecs[12] = mk(1, 1, 5'd9,  6'd33, 0, 32'h0,        0, 0, 5'd3, 32'hA3, 0, 5'd1,  32'hB3, 0, 1);
        vecs[13] = mk(0, 0, 5'd0,  6'd0,  1, 32'hDEAD,     0, 0, 5'd3, 32'hA3, 0, 5'd1,  32'hB3, 0, 0);

        // ---------------- reset ----------------
        rst = 1'b1;
        drive(0, 0, 5'd0, 6'd0, 0, 32'h0);
        tick();
        tick();
        expect_out("reset", 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
        rst = 1'b0;
        tick();
        expect_out("post_reset", 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);

        // ---------------- table ----------------
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].start, vecs[i].bank_sel, vecs[i].base, vecs[i].len, vecs[i].valid, vecs[i].data);
            tick();
            expect_out($sformatf("vec%0d", i), vecs[i].e_busy,
                       vecs[i].e_fwe, vecs[i].e_faddr, vecs[i].e_fdata,
                       vecs[i].e_swe, vecs[i].e_saddr, vecs[i].e_sdata,
                       vecs[i].e_done, vecs[i].e_err);
        end

        // ---------------- stalls: length 3, valid 1,0,0,1,0,1 ----------------
        drive(1, 0, 5'd12, 6'd3, 0, 32'h0);
        tick();
        check("stall start busy", 32'(busy), 32'd1);
        stall_pat = 6'b101001;   // bit i = in_valid in cycle i
        k = 0;
        strobes = 0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 5'd0, 6'd0, stall_pat[i], 32'hC0 + 32'(k));
            tick();
            check($sformatf("stall%0d s_we", i), 32'(bus.s_we), 32'd0);
            if (bus.f_we === 1'b1) strobes++;
            if (stall_pat[i]) begin
                check($sformatf("stall%0d f_we", i),    32'(bus.f_we),   32'd1);
                check($sformatf("stall%0d f_addr", i),  32'(bus.f_addr), 32'd12 + 32'(k));
                check($sformatf("stall%0d f_wdata", i), bus.f_wdata,     32'hC0 + 32'(k));
                check($sformatf("stall%0d done", i),    32'(done),       32'(k == 2));
                k++;
            end else begin
                check($sformatf("stall%0d f_we", i),   32'(bus.f_we),   32'd0);
                check($sformatf("stall%0d f_addr", i), 32'(bus.f_addr), 32'd12 + 32'(k - 1));
                check($sformatf("stall%0d done", i),   32'(done),       32'd0);
                check($sformatf("stall%0d busy", i),   32'(busy),       32'd1);
            end
        end
        check("stall strobe count", 32'(strobes), 32'd3);
        check("stall end busy", 32'(busy), 32'd0);

        // ---------------- ignored start mid-burst ----------------
        drive(1, 0, 5'd10, 6'd8, 0, 32'h0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(i == 2, 1, 5'd5, 6'd2, 1, 32'h100 + 32'(i));
            tick();
            check($sformatf("ign%0d f_we", i),    32'(bus.f_we),   32'd1);
            check($sformatf("ign%0d f_addr", i),  32'(bus.f_addr), 32'd10 + 32'(i));
            check($sformatf("ign%0d f_wdata", i), bus.f_wdata,     32'h100 + 32'(i));
            check($sformatf("ign%0d s_we", i),    32'(bus.s_we),   32'd0);
            check($sformatf("ign%0d done", i),    32'(done),       32'(i == 7));
        end
        drive(0, 0, 5'd0, 6'd0, 1, 32'h1FF);
        tick();
        check("ign after f_we", 32'(bus.f_we), 32'd0);
        check("ign after s_we", 32'(bus.s_we), 32'd0);
        check("ign after busy", 32'(busy), 32'd0);

        // ---------------- reset mid-burst ----------------
        drive(1, 1, 5'd0, 6'd6, 0, 32'h0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 5'd0, 6'd0, 1, 32'hE0 + 32'(i));
            tick();
            check($sformatf("rstb%0d s_we", i),   32'(bus.s_we),   32'd1);
            check($sformatf("rstb%0d s_addr", i), 32'(bus.s_addr), 32'(i));
        end
        drive(0, 0, 5'd0, 6'd0, 1, 32'hE2);
        #2 rst = 1'b1;
        #1;
        expect_out("rst_async", 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
        tick();
        expect_out("rst_held", 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("rst_rel%0d", i), 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
        end
        drive(1, 0, 5'd7, 6'd1, 0, 32'h0);
        tick();
        check("after_rst start busy", 32'(busy), 32'd1);
        drive(0, 0, 5'd0, 6'd0, 1, 32'h77);
        tick();
        expect_out("after_rst word", 0, 1, 5'd7, 32'h77, 0, 5'd0, 32'h0, 1, 0);
        drive(0, 0, 5'd0, 6'd0, 0, 32'h0);
        tick();
        expect_out("after_rst idle", 0, 0, 5'd7, 32'h77, 0, 5'd0, 32'h0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bank_scatter_writer.md
# bank_scatter_writer

Burst writer that fills one of the two 32-entry × 32-bit register banks (F bank, S bank) that the bank-select mux later reads from. It accepts a word stream over a valid/ready handshake and turns it into registered per-bank write strobes (address, data, write enable). A start command fixes the target bank, base address and burst length. It sits upstream of both banks, the write side of the bank pair.

## Interface
Parameters:
- DATA_W, 32, word width of stream and bank write data
- DEPTH, 32, entries per bank; ADDR_W = 5 (log2 DEPTH), fixed

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  burst command strobe; sampled only in IDLE
- bank_sel  in  1  0 = F bank, 1 = S bank; latched on accepted start
- base_addr  in  5  first bank entry written; latched on accepted start
- length  in  6  words in burst; legal 1..32; latched on accepted start
- in_valid  in  1  stream word present
- in_data  in  DATA_W  stream word
- in_ready  out  1  writer accepts a word this cycle
- f_we, f_addr[4:0], f_wdata[DATA_W-1:0]  out  F bank write port, registered
- s_we, s_addr[4:0], s_wdata[DATA_W-1:0]  out  S bank write port, registered
- busy  out  1  high while state is BURST
- done  out  1  one-cycle pulse, coincident with the final write strobe
- err  out  1  one-cycle pulse when start has an illegal length

## Operation
- States: IDLE, BURST.
- IDLE: in_ready = 0, busy = 0.
  - start=1 with 1 ≤ length ≤ 32: latch bank_sel, set addr_ptr = base_addr and remaining = length, go to BURST.
  - start=1 with length = 0 or > 32: err pulses next cycle, stay IDLE, latch nothing.
- BURST: in_ready = 1, busy = 1.
  - A word is accepted on any edge with in_valid & in_ready.
  - On each accept, register data and addr_ptr to the selected bank port and assert that bank's we for one cycle.
  - The other bank's we stays 0.
  - Then addr_ptr increments mod 32 (31 → 0 wrap) and remaining decrements.
  - On the accept with remaining = 1: go to IDLE, and done is asserted together with that word's we.
- in_valid = 0 in BURST: no strobe, no state change. There is no timeout.
- start in BURST is ignored. Latched bank, address and length never change mid-burst.
- start in the cycle done is high: state is already IDLE, so it is accepted normally.
- Write ports: addr and wdata hold their last value when we = 0. f_* and s_* are never both enabled.
- Reset (asynchronous, any state, including mid-burst):
  - state → IDLE, the burst is aborted and no further strobes follow.
  - in_ready, busy, done, err, f_we, s_we → 0; f_addr, s_addr → 0; f_wdata, s_wdata → 0.
  - Internal pointer and counter → 0.

## Timing
- start accepted at edge 0 → busy and in_ready high from cycle 1.
- Word accepted at edge k → we/addr/data valid in cycle k+1, for one cycle (latency 1).
- Throughput: one word per cycle with in_valid held high; a 32-word burst takes 32 accepting edges.
- in_ready drops in the cycle after the final accept; done is high in that same cycle.
- Minimum spacing: back-to-back bursts with no idle gap beyond the one IDLE cycle in which start is sampled.
- err and done are single-cycle pulses and never coincide.

## Test plan
- Basic burst: start, bank_sel=0, base=0, length=4, words 0xA0..0xA3 streamed continuously. Required: f_we high for 4 consecutive cycles at addr 0..3 with data A0..A3; s_we never high; done with the 4th strobe; in_ready low afterwards.
- Wrap and S bank: bank_sel=1, base=30, length=4. Required: s_addr sequence 30, 31, 0, 1; f_we stays 0.
- Stalls: length=3 with in_valid toggling 1,0,0,1,0,1. Required: exactly 3 strobes, each one cycle after its accept; done on the third; no strobe in stall cycles.
- Illegal length: start with length=0, then with length=33. Required: err pulses one cycle each time; busy stays 0; no we.
- Ignored start: start with bank_sel=1 and base=5 issued mid-burst of a length-8 F burst at base 10. Required: all 8 writes go to F at 10..17; the second start is dropped.
- Reset mid-burst: assert rst after 2 of 6 words are accepted. Required: all outputs 0 immediately; no strobes after reset release; the next start at base=7 writes starting at addr 7.
